// File: rtl/spi_master_bmp280_if.sv
// Bundles the BMP280 SPI master's FSM-side handshake and sensor-side pins.
// The master modport is the SPI block's view; the slave modport is the peer's view.
interface spi_master_bmp280_if #(
    parameter int unsigned DATA_WIDTH_SPI_CONFIG = 16
);
    logic                             enable_spi;
    logic [DATA_WIDTH_SPI_CONFIG-1:0] tx_byte_spi;
    logic [DATA_WIDTH_SPI_CONFIG-1:0] rx_byte_spi;
    logic                             busy_spi;
    logic                             complete_spi;
    logic                             sclk;
    logic                             mosi;
    logic                             miso;
    logic                             cs_n;

    modport master (
        input  enable_spi,
        input  tx_byte_spi,
        input  miso,
        output rx_byte_spi,
        output busy_spi,
        output complete_spi,
        output sclk,
        output mosi,
        output cs_n
    );

    modport slave (
        output enable_spi,
        output tx_byte_spi,
        output miso,
        input  rx_byte_spi,
        input  busy_spi,
        input  complete_spi,
        input  sclk,
        input  mosi,
        input  cs_n
    );
endinterface

// File: rtl/spi_master_bmp280.sv
// SPI mode-0 master for the BMP280: shifts one address+data frame out MSB-first,
// captures the same number of MISO bits, and pulses complete_spi at frame end.
// Frames repeat back-to-back while enable_spi is held, separated by a CS-high gap.
module spi_master_bmp280 #(
    parameter int unsigned CLK_FPGA              = 50000000,
    parameter int unsigned CLK_SPI               = 5000000,
    parameter int unsigned DATA_WIDTH_SPI_CONFIG = 16,
    parameter int unsigned CS_GAP_CYCLES         = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_master_bmp280_if.master  bus
);

    localparam int unsigned W            = DATA_WIDTH_SPI_CONFIG;
    localparam int unsigned HALF_DIV_RAW = CLK_FPGA / (2 * CLK_SPI);
    localparam int unsigned HALF_DIV     = (HALF_DIV_RAW < 1) ? 1 : HALF_DIV_RAW;
    localparam int unsigned DIV_W        = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned BIT_W        = $clog2(W + 1);
    localparam int unsigned GAP_W        = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ALL    = BIT_W'(W);
    localparam logic [BIT_W-1:0] BIT_PENULT = BIT_W'(W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP
    } state_t;

    state_t           state_q,    state_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [BIT_W-1:0] bit_q,      bit_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic [W-1:0]     tx_sh_q,    tx_sh_d;
    logic [W-1:0]     rx_sh_q,    rx_sh_d;
    logic [W-1:0]     rx_byte_q,  rx_byte_d;
    logic             cs_n_q,     cs_n_d;
    logic             sclk_q,     sclk_d;
    logic             complete_q, complete_d;
    logic             div_done;

    assign div_done = (div_q == DIV_LAST);

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            complete_q <= complete_d;
        end
    end

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        complete_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable_spi) begin
                    tx_sh_d = bus.tx_byte_spi;
                    cs_n_d  = 1'b0;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = ST_CS_SETUP;
                end
            end

            ST_CS_SETUP: begin
                if (div_done) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[W-2:0], bus.miso};
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (div_done) begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling edge: the last one leaves mosi on the final bit.
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                        if (bit_q != BIT_PENULT) begin
                            tx_sh_d = {tx_sh_q[W-2:0], 1'b0};
                        end
                    end else if (bit_q == BIT_ALL) begin
                        // Last bit has had a full low half-period; release to hold.
                        state_d = ST_CS_HOLD;
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[W-2:0], bus.miso};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_CS_HOLD: begin
                if (div_done) begin
                    div_d      = '0;
                    cs_n_d     = 1'b1;
                    rx_byte_d  = rx_sh_q;
                    complete_d = 1'b1;
                    gap_d      = '0;
                    state_d    = ST_GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // mosi is the head of the TX shift register, so it holds between frames.
    assign bus.mosi         = tx_sh_q[W-1];
    assign bus.sclk         = sclk_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.rx_byte_spi  = rx_byte_q;
    assign bus.complete_spi = complete_q;
    assign bus.busy_spi     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_master_bmp280.sv
// Directed bench for spi_master_bmp280: default-rate DUT plus two fast-SCLK variants.
module tb_spi_master_bmp280;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    spi_master_bmp280_if #(.DATA_WIDTH_SPI_CONFIG(16)) bus0 ();
    spi_master_bmp280_if #(.DATA_WIDTH_SPI_CONFIG(16)) bus1 ();
    spi_master_bmp280_if #(.DATA_WIDTH_SPI_CONFIG(16)) bus2 ();

    spi_master_bmp280 #(
        .CLK_FPGA(50000000), .CLK_SPI(5000000),
        .DATA_WIDTH_SPI_CONFIG(16), .CS_GAP_CYCLES(10)
    ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));

    spi_master_bmp280 #(
        .CLK_FPGA(50000000), .CLK_SPI(25000000),
        .DATA_WIDTH_SPI_CONFIG(16), .CS_GAP_CYCLES(10)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    spi_master_bmp280 #(
        .CLK_FPGA(50000000), .CLK_SPI(100000000),
        .DATA_WIDTH_SPI_CONFIG(16), .CS_GAP_CYCLES(10)
    ) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one frame on bus0 from its acceptance edge, acting as a mode-0 slave.
    // stop_rises>0 ends early after that many sclk rises; drop_rises<0 keeps enable high.
    task automatic run_frame0(
        input  logic [15:0] slave_word,
        input  int          stop_rises,
        input  int          drop_rises,
        input  bit          noise,
        output logic [15:0] mosi_word,
        output int          rises,
        output int          cs_low,
        output int          lat,
        output logic [15:0] rx_at,
        output int          first_rise,
        output int          last_rise
    );
        int   idx;
        logic prev_sclk;
        bit   done;
        mosi_word  = '0;
        rises      = 0;
        cs_low     = 0;
        lat        = 0;
        rx_at      = '0;
        first_rise = 0;
        last_rise  = 0;
        idx        = 0;
        prev_sclk  = 1'b0;
        done       = 1'b0;
        bus0.miso  = slave_word[15];
        for (int edges = 1; edges <= 400 && !done; edges++) begin
            @(posedge clk);
            #1;
            if (bus0.cs_n == 1'b0) cs_low++;
            if (bus0.sclk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[14:0], bus0.mosi};
                if (rises == 1) first_rise = edges;
                last_rise = edges;
            end
            if (!bus0.sclk && prev_sclk) idx++;
            prev_sclk = bus0.sclk;
            bus0.miso = (idx < 16) ? slave_word[4'(15 - idx)] : 1'b0;
            if (bus0.complete_spi) begin
                lat   = edges;
                rx_at = bus0.rx_byte_spi;
                done  = 1'b1;
            end
            if (stop_rises > 0 && rises >= stop_rises) done = 1'b1;
            if (drop_rises >= 0 && rises >= drop_rises) bus0.enable_spi = 1'b0;
            if (noise) bus0.tx_byte_spi = 16'($urandom);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus0.cs_n !== 1'b1) begin fails++; $display("FAIL rst_cs_n: got %b expected 1", bus0.cs_n); end
        tests++; if (bus0.sclk !== 1'b0) begin fails++; $display("FAIL rst_sclk: got %b expected 0", bus0.sclk); end
        tests++; if (bus0.mosi !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b expected 0", bus0.mosi); end
        tests++; if (bus0.busy_spi !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", bus0.busy_spi); end
        tests++; if (bus0.complete_spi !== 1'b0) begin fails++; $display("FAIL rst_complete: got %b expected 0", bus0.complete_spi); end
        tests++; if (bus0.rx_byte_spi !== 16'h0000) begin fails++; $display("FAIL rst_rx: got %h expected 0000", bus0.rx_byte_spi); end
        tests++; if (bus1.cs_n !== 1'b1 || bus2.cs_n !== 1'b1) begin fails++; $display("FAIL rst_cs_n_fast: got %b%b expected 11", bus1.cs_n, bus2.cs_n); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_config_write;
        logic [15:0] mw, rx;
        int r, csl, lat, fr, lr, extra_c, extra_cs;
        bus0.tx_byte_spi = 16'h7510;
        bus0.enable_spi  = 1'b1;
        run_frame0(16'h0000, 0, 0, 1'b0, mw, r, csl, lat, rx, fr, lr);
        tests++; if (mw !== 16'h7510) begin fails++; $display("FAIL cfg_mosi: got %h expected 7510", mw); end
        tests++; if (r != 16) begin fails++; $display("FAIL cfg_rises: got %0d expected 16", r); end
        tests++; if (csl != 170) begin fails++; $display("FAIL cfg_cs_low: got %0d expected 170", csl); end
        tests++; if (lat != 171) begin fails++; $display("FAIL cfg_latency: got %0d expected 171", lat); end
        tests++; if (fr != 6) begin fails++; $display("FAIL cfg_first_rise: got %0d expected 6", fr); end
        tests++; if (lr - fr != 150) begin fails++; $display("FAIL cfg_sclk_period: got %0d expected 150", lr - fr); end
        extra_c  = 0;
        extra_cs = 0;
        repeat (11) begin
            @(posedge clk);
            #1;
            if (bus0.complete_spi) extra_c++;
            if (!bus0.cs_n) extra_cs++;
        end
        tests++; if (extra_c != 0) begin fails++; $display("FAIL cfg_single_pulse: got %0d extra pulses expected 0", extra_c); end
        tests++; if (extra_cs != 0) begin fails++; $display("FAIL cfg_no_refire: got %0d cs low cycles expected 0", extra_cs); end
        tests++; if (bus0.busy_spi !== 1'b0) begin fails++; $display("FAIL cfg_idle_busy: got %b expected 0", bus0.busy_spi); end
    endtask

    task automatic test_temp_read;
        logic [15:0] mw, rx;
        int r, csl, lat, fr, lr;
        bus0.tx_byte_spi = 16'hFA00;
        bus0.enable_spi  = 1'b1;
        run_frame0(16'hFF80, 0, 0, 1'b0, mw, r, csl, lat, rx, fr, lr);
        tests++; if (rx !== 16'hFF80) begin fails++; $display("FAIL rd_rx: got %h expected ff80", rx); end
        tests++; if (mw !== 16'hFA00) begin fails++; $display("FAIL rd_mosi: got %h expected fa00", mw); end
        repeat (20) @(posedge clk);
        #1;
        tests++; if (bus0.rx_byte_spi !== 16'hFF80) begin fails++; $display("FAIL rd_rx_hold: got %h expected ff80", bus0.rx_byte_spi); end
        tests++; if (bus0.busy_spi !== 1'b0) begin fails++; $display("FAIL rd_idle: got %b expected 0", bus0.busy_spi); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] mw, rx;
        int r, csl, lat, fr, lr, high;
        bus0.tx_byte_spi = 16'h7510;
        bus0.enable_spi  = 1'b1;
        run_frame0(16'h1234, 0, -1, 1'b0, mw, r, csl, lat, rx, fr, lr);
        tests++; if (lat != 171) begin fails++; $display("FAIL b2b_lat1: got %0d expected 171", lat); end
        tests++; if (mw !== 16'h7510) begin fails++; $display("FAIL b2b_mosi1: got %h expected 7510", mw); end
        bus0.tx_byte_spi = 16'hF4A5;
        high = (bus0.cs_n === 1'b1) ? 1 : 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus0.cs_n === 1'b1) high++;
        end
        tests++; if (high != 11) begin fails++; $display("FAIL b2b_gap: got %0d expected 11", high); end
        run_frame0(16'hBEEF, 0, 0, 1'b0, mw, r, csl, lat, rx, fr, lr);
        tests++; if (lat != 171) begin fails++; $display("FAIL b2b_lat2: got %0d expected 171", lat); end
        tests++; if (csl != 170) begin fails++; $display("FAIL b2b_cs_low2: got %0d expected 170", csl); end
        tests++; if (mw !== 16'hF4A5) begin fails++; $display("FAIL b2b_mosi2: got %h expected f4a5", mw); end
        tests++; if (rx !== 16'hBEEF) begin fails++; $display("FAIL b2b_rx2: got %h expected beef", rx); end
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] mw, rx;
        int r, csl, lat, fr, lr, stray;
        bus0.tx_byte_spi = 16'hFE5A;
        bus0.enable_spi  = 1'b1;
        run_frame0(16'hFFFF, 7, 0, 1'b0, mw, r, csl, lat, rx, fr, lr);
        tests++; if (r != 7) begin fails++; $display("FAIL rstm_rises: got %0d expected 7", r); end
        tests++; if (bus0.mosi !== 1'b1) begin fails++; $display("FAIL rstm_mosi_pre: got %b expected 1", bus0.mosi); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (bus0.cs_n !== 1'b1) begin fails++; $display("FAIL rstm_cs_n: got %b expected 1", bus0.cs_n); end
        tests++; if (bus0.sclk !== 1'b0) begin fails++; $display("FAIL rstm_sclk: got %b expected 0", bus0.sclk); end
        tests++; if (bus0.mosi !== 1'b0) begin fails++; $display("FAIL rstm_mosi: got %b expected 0", bus0.mosi); end
        tests++; if (bus0.busy_spi !== 1'b0) begin fails++; $display("FAIL rstm_busy: got %b expected 0", bus0.busy_spi); end
        tests++; if (bus0.complete_spi !== 1'b0) begin fails++; $display("FAIL rstm_complete: got %b expected 0", bus0.complete_spi); end
        tests++; if (bus0.rx_byte_spi !== 16'h0000) begin fails++; $display("FAIL rstm_rx: got %h expected 0000", bus0.rx_byte_spi); end
        rst_n = 1'b1;
        stray = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (bus0.complete_spi || !bus0.cs_n) stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL rstm_no_partial: got %0d active cycles expected 0", stray); end
        bus0.tx_byte_spi = 16'h1234;
        bus0.enable_spi  = 1'b1;
        run_frame0(16'h5A5A, 0, 0, 1'b0, mw, r, csl, lat, rx, fr, lr);
        tests++; if (lat != 171) begin fails++; $display("FAIL rstm_new_lat: got %0d expected 171", lat); end
        tests++; if (mw !== 16'h1234) begin fails++; $display("FAIL rstm_new_mosi: got %h expected 1234", mw); end
        tests++; if (rx !== 16'h5A5A) begin fails++; $display("FAIL rstm_new_rx: got %h expected 5a5a", rx); end
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_enable_drop;
        logic [15:0] mw, rx;
        int r, csl, lat, fr, lr, extra;
        bus0.tx_byte_spi = 16'hC3A5;
        bus0.enable_spi  = 1'b1;
        run_frame0(16'h0F0F, 0, 3, 1'b1, mw, r, csl, lat, rx, fr, lr);
        tests++; if (mw !== 16'hC3A5) begin fails++; $display("FAIL drop_mosi: got %h expected c3a5", mw); end
        tests++; if (lat != 171) begin fails++; $display("FAIL drop_lat: got %0d expected 171", lat); end
        tests++; if (rx !== 16'h0F0F) begin fails++; $display("FAIL drop_rx: got %h expected 0f0f", rx); end
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus0.complete_spi || !bus0.cs_n) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL drop_no_new_frame: got %0d active cycles expected 0", extra); end
        tests++; if (bus0.busy_spi !== 1'b0) begin fails++; $display("FAIL drop_idle: got %b expected 0", bus0.busy_spi); end
    endtask

    task automatic test_param_sweep;
        logic [15:0] mw1, mw2;
        logic        p1, p2;
        int r1, r2, f1, f2, s1, s2, lat1, lat2;
        logic [15:0] rx1, rx2;
        mw1 = '0; mw2 = '0; p1 = 1'b0; p2 = 1'b0;
        r1 = 0; r2 = 0; f1 = 0; f2 = 0; s1 = 0; s2 = 0; lat1 = 0; lat2 = 0;
        rx1 = '0; rx2 = '0;
        bus1.miso = 1'b1;
        bus2.miso = 1'b1;
        bus1.tx_byte_spi = 16'h9C31;
        bus2.tx_byte_spi = 16'h9C31;
        bus1.enable_spi  = 1'b1;
        bus2.enable_spi  = 1'b1;
        for (int edges = 1; edges <= 100 && (lat1 == 0 || lat2 == 0); edges++) begin
            @(posedge clk);
            #1;
            bus1.enable_spi = 1'b0;
            bus2.enable_spi = 1'b0;
            if (bus1.sclk && !p1) begin
                r1++;
                mw1 = {mw1[14:0], bus1.mosi};
                if (r1 == 1) f1 = edges;
                if (r1 == 2) s1 = edges;
            end
            if (bus2.sclk && !p2) begin
                r2++;
                mw2 = {mw2[14:0], bus2.mosi};
                if (r2 == 1) f2 = edges;
                if (r2 == 2) s2 = edges;
            end
            p1 = bus1.sclk;
            p2 = bus2.sclk;
            if (bus1.complete_spi && lat1 == 0) begin lat1 = edges; rx1 = bus1.rx_byte_spi; end
            if (bus2.complete_spi && lat2 == 0) begin lat2 = edges; rx2 = bus2.rx_byte_spi; end
        end
        tests++; if (lat1 != 35) begin fails++; $display("FAIL sweep25_lat: got %0d expected 35", lat1); end
        tests++; if (lat2 != 35) begin fails++; $display("FAIL sweep100_lat: got %0d expected 35", lat2); end
        tests++; if (s1 - f1 != 2) begin fails++; $display("FAIL sweep25_period: got %0d expected 2", s1 - f1); end
        tests++; if (s2 - f2 != 2) begin fails++; $display("FAIL sweep100_period: got %0d expected 2", s2 - f2); end
        tests++; if (mw1 !== 16'h9C31) begin fails++; $display("FAIL sweep25_mosi: got %h expected 9c31", mw1); end
        tests++; if (mw2 !== 16'h9C31) begin fails++; $display("FAIL sweep100_mosi: got %h expected 9c31", mw2); end
        tests++; if (rx1 !== 16'hFFFF) begin fails++; $display("FAIL sweep25_rx: got %h expected ffff", rx1); end
        tests++; if (rx2 !== 16'hFFFF) begin fails++; $display("FAIL sweep100_rx: got %h expected ffff", rx2); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus0.enable_spi = 1'b0; bus0.tx_byte_spi = '0; bus0.miso = 1'b0;
        bus1.enable_spi = 1'b0; bus1.tx_byte_spi = '0; bus1.miso = 1'b0;
        bus2.enable_spi = 1'b0; bus2.tx_byte_spi = '0; bus2.miso = 1'b0;
        test_reset();
        test_config_write();
        test_temp_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable_drop();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
